// File: rtl/mem_arbiter_nport.sv
// N-port arbiter in front of a pipelined fixed-latency memory; read data is routed back through an in-order tag FIFO.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest-index port has fixed priority.
module mem_arbiter_nport #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_valid,
  output logic                        tag_err
);
  localparam int TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [TAG_W-1:0]  r_fifo [MEM_LAT];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_cnt, r_drain;
  logic              r_tag_err, r_mem_en, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [TAG_W-1:0]  r_ptr;
`endif

  logic [ADDR_W-1:0]    w_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    w_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_elig;
  logic [TAG_W-1:0]     w_sel, w_idx, w_head_tag;
  logic                 w_any, w_gvalid, w_push, w_pop, w_room, w_draining;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(MEM_LAT - 1)) ? '0 : v + 1'b1;
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_addr[p]  = addr[p*ADDR_W +: ADDR_W];
    assign w_wdata[p] = wdata[p*DATA_W +: DATA_W];
    assign gnt[p]     = w_gvalid && (w_sel == TAG_W'(p));
    assign rvalid[p]  = w_pop && (w_head_tag == TAG_W'(p));
  end

  // A pop in the same cycle frees its slot, so a stalled read can go the cycle data returns.
  assign w_draining = (r_drain != '0);
  assign w_head_tag = r_fifo[r_head];
  assign w_pop      = mem_valid && !w_draining && (r_cnt != '0);
  assign w_room     = (r_cnt < CNT_W'(MEM_LAT)) || w_pop;
  assign w_elig     = req & (we | {NUM_PORTS{w_room}});
  assign w_gvalid   = w_any && rst;
  assign w_push     = w_gvalid && !we[w_sel];
  assign rdata      = w_pop ? mem_rdata : '0;

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = TAG_W'((int'(r_ptr) + i) % NUM_PORTS);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
`else
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_idx = TAG_W'(i);
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= '0;
      r_drain     <= CNT_W'(MEM_LAT);
      r_tag_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_ptr       <= TAG_W'(NUM_PORTS - 1);
`endif
    end else begin
      r_mem_en    <= w_gvalid;
      r_mem_wr    <= w_gvalid && we[w_sel];
      r_mem_addr  <= w_addr[w_sel];
      r_mem_wdata <= w_wdata[w_sel];
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop)  r_head <= f_inc(r_head);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      if (w_draining) r_drain <= r_drain - 1'b1;
      if (mem_valid && !w_draining && (r_cnt == '0)) r_tag_err <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (w_gvalid) r_ptr <= w_sel;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_tail] <= w_sel;
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign tag_err   = r_tag_err;
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: queue-based reference model checked every cycle, a latency-accurate memory,
// and directed scenarios with hand-computed expectations.
module tb_mem_arbiter_nport;
  localparam int NP  = 3;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req, we;
  logic [NP*16-1:0] addr, wdata;
  logic [NP-1:0] gnt, rvalid;
  logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
  logic          mem_en, mem_wr, mem_valid, tag_err;
  logic          mv_mem, inj_v;

  mem_arbiter_nport #(.NUM_PORTS(NP), .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .tag_err(tag_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A00);
  endfunction

  // Memory: a read command seen in cycle c returns data in cycle c+LAT.
  int cyc = 0;
  bit          resp_v [0:4095];
  logic [15:0] resp_d [0:4095];
  assign mem_valid = mv_mem | inj_v;
  initial begin
    mv_mem = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      mv_mem    = resp_v[cyc];
      mem_rdata = resp_v[cyc] ? resp_d[cyc] : 16'hDEAD;
    end
  end

  // Reference model: outstanding reads as a queue of (port, expected data).
  int          q_tag[$];
  logic [15:0] q_dat[$];
  int          dr, last;
  bit          armed = 0, e_en, e_wr, e_err;
  logic [15:0] e_addr, e_wd;

  always @(negedge clk) begin
    bit pop, room;
    int g;
    logic [NP-1:0] egnt, erv;
    logic [15:0] erd;
    pop  = armed && mem_valid && (dr == 0) && (q_tag.size() > 0);
    room = (q_tag.size() < LAT) || pop;
    g = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++)
      if (g < 0 && req[(last + k) % NP] && (we[(last + k) % NP] || room)) g = (last + k) % NP;
`else
    for (int p = 0; p < NP; p++)
      if (g < 0 && req[p] && (we[p] || room)) g = p;
`endif
    egnt = (rst && g >= 0) ? NP'(1 << g) : '0;
    erv  = pop ? NP'(1 << q_tag[0]) : '0;
    erd  = pop ? q_dat[0] : 16'h0;
    if (armed) begin
      chk("gnt", gnt, egnt);
      chk("rvalid", rvalid, erv);
      chk("rdata", rdata, erd);
      chk("mem_en", mem_en, e_en);
      chk("mem_wr", mem_wr, e_wr);
      if (e_en) chk("mem_addr", mem_addr, e_addr);
      if (e_en && e_wr) chk("mem_wdata", mem_wdata, e_wd);
      chk("tag_err", tag_err, e_err);
      if (mem_en === 1'b1 && mem_wr === 1'b0) begin
        resp_v[cyc + LAT] = 1'b1;
        resp_d[cyc + LAT] = mem_f(mem_addr);
      end
    end
    if (!rst) begin
      q_tag.delete(); q_dat.delete();
      dr = LAT; last = NP - 1;
      e_en = 0; e_wr = 0; e_err = 0; armed = 1;
    end else if (armed) begin
      if (dr == 0 && mem_valid) begin
        if (q_tag.size() == 0) e_err = 1;
        else begin
          void'(q_tag.pop_front());
          void'(q_dat.pop_front());
        end
      end
      if (dr > 0) dr--;
      e_en = (g >= 0);
      e_wr = (g >= 0) && we[g];
      if (g >= 0) begin
        e_addr = addr[g*16 +: 16];
        e_wd   = wdata[g*16 +: 16];
        last   = g;
        if (!we[g]) begin
          q_tag.push_back(g);
          q_dat.push_back(mem_f(addr[g*16 +: 16]));
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0; we = '0;
    repeat (n) step();
  endtask

  task automatic set_addr(input int p, input logic [15:0] a);
    addr[p*16 +: 16] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int gcyc[5];
    int gport[6];
    int ng;
    int exp_b2b[5];
    int exp_cont[6];
    exp_b2b = '{0, 1, 2, 3, 5};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_cont = '{0, 1, 2, 0, 1, 2};
`else
    exp_cont = '{0, 0, 0, 0, 0, 0};
`endif
    rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; inj_v = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_tag_err", tag_err, 0);
    step(); rst = 1'b1;
    idle(6);

    // Single read by port 1
    req = 3'b010; set_addr(1, 16'h0040);
    @(negedge clk); chk("t1_gnt", gnt, 3'b010);
    step(); req = '0;
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 16'h0040);
    repeat (4) step();
    @(negedge clk);
    chk("t1_rvalid", rvalid, 3'b010);
    chk("t1_rdata", rdata, 16'hBEEF);
    idle(4);

    // Back-to-back reads by port 0, stall at four outstanding
    ng = 0;
    req = 3'b001; set_addr(0, 16'h0010);
    for (int c = 0; c < 20 && ng < 5; c++) begin
      @(negedge clk);
      if (gnt[0]) begin gcyc[ng] = c; ng++; end
      step();
      if (ng < 5) set_addr(0, 16'h0010 + 16'(ng));
      else req = '0;
    end
    chk("t2_ngrants", ng, 5);
    for (int i = 0; i < 5; i++) chk("t2_gnt_cycle", gcyc[i], exp_b2b[i]);
    idle(8);

    // Port 2 write so the round-robin search next starts at port 0
    req = 3'b100; we = 3'b100; set_addr(2, 16'h0090); wdata[32 +: 16] = 16'h5555;
    @(negedge clk); chk("t3_pre_gnt", gnt, 3'b100);
    step(); req = '0; we = '0;

    // Contention: all ports read continuously
    ng = 0;
    req = 3'b111; set_addr(0, 16'h0100); set_addr(1, 16'h0101); set_addr(2, 16'h0102);
    for (int c = 0; c < 30 && ng < 6; c++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        if (gnt[p] && ng < 6) begin gport[ng] = p; ng++; end
      step();
    end
    req = '0;
    chk("t3_ngrants", ng, 6);
    for (int i = 0; i < 6; i++) chk("t3_gnt_port", gport[i], exp_cont[i]);
    idle(10);

    // Write bypass with the FIFO full
    req = 3'b001; we = '0; set_addr(0, 16'h0020);
    repeat (4) step();
    req = 3'b011; we = 3'b001; set_addr(0, 16'h0080); wdata[15:0] = 16'h1234; set_addr(1, 16'h0030);
    @(negedge clk); chk("t4_gnt_write", gnt, 3'b001);
    step(); req = 3'b010; we = '0;
    @(negedge clk);
    chk("t4_mem_en", mem_en, 1);
    chk("t4_mem_wr", mem_wr, 1);
    chk("t4_mem_addr", mem_addr, 16'h0080);
    chk("t4_mem_wdata", mem_wdata, 16'h1234);
    chk("t4_rvalid", rvalid, 3'b001);
    chk("t4_gnt_read", gnt, 3'b010);
    step();
    idle(10);

    // Reset two cycles after a read grant
    req = 3'b010; set_addr(1, 16'h0050);
    @(negedge clk); chk("t5_gnt", gnt, 3'b010);
    step(); req = '0;
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t5_gnt0", gnt, 0);
    chk("t5_rvalid0", rvalid, 0);
    chk("t5_rdata0", rdata, 0);
    chk("t5_mem_en0", mem_en, 0);
    chk("t5_mem_wr0", mem_wr, 0);
    chk("t5_mem_addr0", mem_addr, 0);
    chk("t5_mem_wdata0", mem_wdata, 0);
    chk("t5_tag_err0", tag_err, 0);
    repeat (2) step();
    @(negedge clk);
    chk("t5_stale_rvalid", rvalid, 0);
    idle(6);
    @(negedge clk); chk("t5_stale_tag_err", tag_err, 0);

    // Spurious mem_valid after the drain window
    inj_v = 1'b1;
    @(negedge clk); chk("t6_rvalid", rvalid, 0);
    step(); inj_v = 1'b0;
    @(negedge clk); chk("t6_tag_err_set", tag_err, 1);
    repeat (3) step();
    @(negedge clk); chk("t6_tag_err_sticky", tag_err, 1);
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk); chk("t6_tag_err_clr", tag_err, 0);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
